// File: rtl/lmsm_seq.sv
// lmsm_seq: load/store-multiple sequencer for the IITB-RISC EX stage.
// Expands an 8-bit register mask into single-register memory transfers
// at consecutive addresses, freezing upstream stages while running.
// Optional feature macro: LMSM_SKIP_EMPTY_EN
//   defined   -> priority encoder visits only set mask bits
//   undefined -> 3-bit index scans all 8 mask bits
module lmsm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_sm,
  input  logic [7:0]  imm,
  input  logic [15:0] base,
  input  logic        hold,
  input  logic        flush,
  output logic        busy,
  output logic        stall_out,
  output logic        valid_out,
  output logic [2:0]  reg_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_write,
  output logic        reg_write,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_pending;
  logic [15:0] r_addr;
  logic [2:0]  r_idx;
  logic        r_is_sm;

  logic [2:0]  w_cur;
  logic        w_run;
  logic        w_valid;
  logic [7:0]  w_pend_clr;

`ifdef LMSM_SKIP_EMPTY_EN
  // Lowest set bit of the pending mask selects the current transfer.
  always_comb begin
    w_cur = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) w_cur = i[2:0];
    end
  end
`else
  // Scan index selects the current mask bit, set or not.
  always_comb begin
    w_cur = r_idx;
  end
`endif

  assign w_run      = (r_state == S_RUN);
  assign w_valid    = w_run & r_pending[w_cur];
  assign w_pend_clr = r_pending & ~(8'b1 << w_cur);

  // Sequencer state and transfer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 8'h00;
      r_addr    <= 16'h0000;
      r_idx     <= 3'd0;
      r_is_sm   <= 1'b0;
    end else if (flush) begin
      // Drop the remaining transfers; no done pulse.
      r_state   <= S_IDLE;
      r_pending <= 8'h00;
      r_idx     <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pending <= imm;
            r_addr    <= base;
            r_is_sm   <= is_sm;
            r_idx     <= 3'd0;
            r_state   <= (imm != 8'h00) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (w_valid) begin
              r_pending <= w_pend_clr;
              r_addr    <= r_addr + 16'd1;
            end
`ifdef LMSM_SKIP_EMPTY_EN
            if (w_valid && (w_pend_clr == 8'h00)) r_state <= S_DONE;
`else
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; gated by rst so outputs read as reset values during reset.
  always_comb begin
    busy      = ~rst & ((r_state == S_RUN) | (r_state == S_DONE));
    stall_out = ~rst & ((start & (r_state == S_IDLE)) | w_run);
    valid_out = ~rst & w_valid;
    reg_addr  = rst ? 3'd0 : w_cur;
    mem_addr  = rst ? 16'h0000 : r_addr;
    mem_rd    = ~rst & w_valid & ~r_is_sm;
    mem_write = ~rst & w_valid & r_is_sm;
    reg_write = ~rst & w_valid & ~r_is_sm;
    done      = ~rst & (r_state == S_DONE);
  end

endmodule

// File: tb/tb_lmsm_seq.sv
// Testbench for lmsm_seq: directed scenarios plus randomized traffic,
// checked against a slot-list reference model of the sequence.
module tb_lmsm_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_sm, hold, flush;
  logic [7:0]  imm;
  logic [15:0] base;
  logic        busy, stall_out, valid_out, mem_rd, mem_write, reg_write, done;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;

  int n_vec = 0;
  int n_err = 0;

  lmsm_seq dut (
    .clk(clk), .rst(rst), .start(start), .is_sm(is_sm), .imm(imm),
    .base(base), .hold(hold), .flush(flush), .busy(busy),
    .stall_out(stall_out), .valid_out(valid_out), .reg_addr(reg_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_write(mem_write),
    .reg_write(reg_write), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a sequence is a list of RUN slots, each consumed by
  // one non-held cycle. 0 idle, 1 run, 2 done.
  int          m_phase = 0;
  int          m_k, m_n;
  logic        m_sm;
  logic        m_fresh = 1'b0;
  logic        sv [8];
  logic [2:0]  sr [8];
  logic [15:0] sa [8];
  int          xfer_cnt;

  task automatic build_slots(input logic [7:0] m, input logic [15:0] b);
    int cnt;
    cnt = 0;
    m_n = 0;
`ifdef LMSM_SKIP_EMPTY_EN
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        sv[m_n] = 1'b1; sr[m_n] = 3'(k); sa[m_n] = b + 16'(cnt);
        cnt++; m_n++;
      end
    end
`else
    for (int k = 0; k < 8; k++) begin
      sv[k] = m[k]; sr[k] = 3'(k); sa[k] = b + 16'(cnt);
      if (m[k]) cnt++;
    end
    m_n = (m == 8'h00) ? 0 : 8;
`endif
    m_k = 0;
  endtask

  task automatic step(input logic s, input logic sm, input logic [7:0] m,
                      input logic [15:0] b, input logic h, input logic f,
                      input logic r);
    @(posedge clk); #1;
    start = s; is_sm = sm; imm = m; base = b; hold = h; flush = f; rst = r;
    #1;
    if (r) begin
      check_val("rst_busy", busy, 0);      check_val("rst_stall", stall_out, 0);
      check_val("rst_valid", valid_out, 0); check_val("rst_rd", mem_rd, 0);
      check_val("rst_wr", mem_write, 0);   check_val("rst_rw", reg_write, 0);
      check_val("rst_done", done, 0);      check_val("rst_reg", reg_addr, 0);
      check_val("rst_addr", mem_addr, 0);
      m_phase = 0; m_fresh = 1'b1;
      return;
    end
    case (m_phase)
      0: begin
        check_val("idle_busy", busy, 0);
        check_val("idle_stall", stall_out, s);
        check_val("idle_valid", valid_out, 0);
        check_val("idle_done", done, 0);
        if (m_fresh) begin
          check_val("post_rst_reg", reg_addr, 0);
          check_val("post_rst_addr", mem_addr, 0);
        end
      end
      1: begin
        check_val("run_busy", busy, 1);
        check_val("run_stall", stall_out, 1);
        check_val("run_done", done, 0);
        check_val("run_valid", valid_out, sv[m_k]);
        check_val("run_reg", reg_addr, sr[m_k]);
        check_val("run_addr", mem_addr, sa[m_k]);
        check_val("run_rd", mem_rd, sv[m_k] & ~m_sm);
        check_val("run_wr", mem_write, sv[m_k] & m_sm);
        check_val("run_rw", reg_write, sv[m_k] & ~m_sm);
      end
      default: begin
        check_val("done_busy", busy, 1);
        check_val("done_stall", stall_out, 0);
        check_val("done_valid", valid_out, 0);
        check_val("done_pulse", done, 1);
      end
    endcase
    if (valid_out && !hold) xfer_cnt++;
    // Model transition at the coming edge.
    if (f) m_phase = 0;
    else begin
      case (m_phase)
        0: if (s) begin
             m_fresh = 1'b0; m_sm = sm;
             build_slots(m, b);
             m_phase = (m_n == 0) ? 2 : 1;
           end
        1: if (!h) begin
             m_k++;
             if (m_k == m_n) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic idle_cycle();
    step(0, 0, 8'h00, 16'h0000, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start = 0; is_sm = 0; imm = 0; base = 0; hold = 0; flush = 0;
    step(0, 0, 8'h00, 16'h0, 0, 0, 1);
    step(0, 0, 8'h00, 16'h0, 0, 0, 1);
    idle_cycle();

    // LM 0x05 from 0x0100
    step(1, 0, 8'h05, 16'h0100, 0, 0, 0);
    repeat (10) idle_cycle();

    // SM 0x81 from 0xFFFF: address wrap
    step(1, 1, 8'h81, 16'hFFFF, 0, 0, 0);
    repeat (10) idle_cycle();

    // Empty mask
    step(1, 0, 8'h00, 16'h1234, 0, 0, 0);
    repeat (3) idle_cycle();

    // 0xFF with 3 hold cycles after the first transfer
    xfer_cnt = 0;
    step(1, 0, 8'hFF, 16'h2000, 0, 0, 0);
    idle_cycle();
    repeat (3) step(0, 0, 8'h00, 16'h0, 1, 0, 0);
    repeat (10) idle_cycle();
    check_val("ff_xfer_count", xfer_cnt, 8);

    // Flush after 2 transfers of 0x0F, then restart next cycle
    step(1, 1, 8'h0F, 16'h3000, 0, 0, 0);
    idle_cycle(); idle_cycle();
    step(0, 0, 8'h00, 16'h0, 0, 1, 0);
    step(1, 0, 8'h03, 16'h4000, 0, 0, 0);
    repeat (10) idle_cycle();

    // start during RUN ignored, sequence completes unchanged
    step(1, 0, 8'hA5, 16'h5000, 0, 0, 0);
    idle_cycle();
    step(1, 1, 8'h11, 16'h9999, 0, 0, 0);
    repeat (10) idle_cycle();

    // Reset mid-sequence
    step(1, 1, 8'h3C, 16'h6000, 0, 0, 0);
    idle_cycle(); idle_cycle();
    step(0, 0, 8'h00, 16'h0, 0, 0, 1);
    repeat (2) idle_cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic       s, sm, h, f;
      logic [7:0] m;
      logic [15:0] b;
      s  = ($urandom_range(0, 99) < 35);
      sm = 1'($urandom);
      h  = ($urandom_range(0, 99) < 25);
      f  = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 9))
        0: m = 8'h00;
        1: m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      b = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      step(s, sm, m, b, h, f, ($urandom_range(0, 199) == 0));
    end
    repeat (12) idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
